avalon_st_arbiter: RTL

AVALON_ST_ARBITER -- requirements
Module: avalon_st_arbiter

---
 rtl/avalon_pkg.sv | 18 +
 rtl/avalon_st_arbiter_if.sv | 37 +++
 rtl/avalon_rr_pick.sv | 26 ++
 rtl/avalon_st_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pkg
// Purpose  : Shared state encoding and default width for the Avalon-ST arbiter.
// Revision : 1.0
// ============================================================================
package avalon_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/avalon_st_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_st_arbiter_if
// Purpose  : Two Avalon-ST sinks and one source bundled for the arbiter.
// Revision : 1.0
// ============================================================================
interface avalon_st_arbiter_if
  import avalon_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              out_chan;

  // Arbiter side
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_chan
  );

  // Stream producer / consumer side
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_chan
  );

endinterface
`default_nettype wire

// File: rtl/avalon_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : avalon_rr_pick
// Purpose  : Two-way round-robin pick; on a tie the input not last granted wins.
// Revision : 1.0
// ============================================================================
module avalon_rr_pick
  import avalon_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick
);

  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/avalon_st_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_st_arbiter
// Purpose  : Two-input Avalon-ST round-robin arbiter with bounded bursts.
// Revision : 1.0
// ============================================================================
module avalon_st_arbiter
  import avalon_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BURST  = 3
) (
  input  logic                clk,
  input  logic                resetn,
  avalon_st_arbiter_if.slave  bus,
  output logic                busy
);

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  arb_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last, last_nxt;
  logic       pick;
  logic       grant_ch;
  logic       own_valid;
  logic       other_valid;

  avalon_rr_pick u_rr_pick (
    .req  ({bus.in1_valid, bus.in0_valid}),
    .last (last),
    .pick (pick)
  );

  // The reset port is active-high despite its name.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  assign grant_ch    = (state == GRANT1);
  assign own_valid   = grant_ch ? bus.in1_valid : bus.in0_valid;
  assign other_valid = grant_ch ? bus.in0_valid : bus.in1_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (bus.in0_valid || bus.in1_valid) begin
          state_nxt = pick ? GRANT1 : GRANT0;
          last_nxt  = pick;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_valid) begin
          cnt_nxt = 4'd0;
          if (other_valid) begin
            state_nxt = grant_ch ? GRANT0 : GRANT1;
            last_nxt  = ~grant_ch;
          end else begin
            state_nxt = IDLE;
          end
        end else if (bus.out_ready) begin
          if (cnt == BURST_LAST) begin
            // Burst end: hand over if the other side waits, else re-enter own grant.
            cnt_nxt = 4'd0;
            if (other_valid) begin
              state_nxt = grant_ch ? GRANT0 : GRANT1;
              last_nxt  = ~grant_ch;
            end else begin
              state_nxt = state;
              last_nxt  = grant_ch;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = {DATA_W{1'b0}};
    bus.out_chan  = 1'b0;
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    busy          = 1'b0;
    case (state)
      GRANT0: begin
        bus.out_valid = bus.in0_valid;
        bus.out_data  = bus.in0_valid ? bus.in0_data : {DATA_W{1'b0}};
        bus.in0_ready = bus.out_ready;
        busy          = 1'b1;
      end
      GRANT1: begin
        bus.out_valid = bus.in1_valid;
        bus.out_data  = bus.in1_valid ? bus.in1_data : {DATA_W{1'b0}};
        bus.in1_ready = bus.out_ready;
        bus.out_chan  = 1'b1;
        busy          = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
